// File: rtl/c2f_consumer.sv
// c2f_consumer: drains CPU->FPGA ring chunks from the C2F RAM into a 64-bit valid/ready stream
module c2f_consumer #(
  parameter int INDEX_NBITS  = 2,
  parameter int OFFSET_NBITS = 4
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic [INDEX_NBITS-1:0]              wrPtr_in,
  output logic [INDEX_NBITS-1:0]              rdPtr_out,
  output logic                                dtAck_out,
  output logic [INDEX_NBITS+OFFSET_NBITS-1:0] ramAddr_out,
  input  logic [63:0]                         ramData_in,
  output logic [63:0]                         data_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                last_out
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state;
  logic [INDEX_NBITS-1:0] rdPtr;
  logic [OFFSET_NBITS-1:0] offset;
  logic [63:0] fifoData [2];
  logic [1:0] fifoLast;
  logic head;
  logic [1:0] count;
  logic inflight, inflightLast;
  logic pop, issue, lastAccept;
  logic [1:0] occ;
  always_comb begin
    valid_out   = count != 2'd0;
    data_out    = valid_out ? fifoData[head] : '0;
    last_out    = valid_out & fifoLast[head];
    pop         = valid_out & ready_in;
    lastAccept  = pop & last_out;
    dtAck_out   = state == DRAIN && lastAccept;
    occ         = count + {1'b0, inflight} - {1'b0, pop};
    issue       = state == STREAM && occ < 2'd2;
    rdPtr_out   = rdPtr;
    ramAddr_out = {rdPtr, offset};
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state        <= IDLE;
      rdPtr        <= '0;
      offset       <= '0;
      head         <= 1'b0;
      count        <= 2'd0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflightLast <= &offset;
      // the returning read lands behind whatever is still queued
      if (inflight) begin
        fifoData[head ^ count[0]] <= ramData_in;
        fifoLast[head ^ count[0]] <= inflightLast;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, inflight} - {1'b0, pop};
      case (state)
        IDLE: begin
          offset <= '0;
          if (rdPtr != wrPtr_in) state <= STREAM;
        end
        STREAM: if (issue) begin
          offset <= offset + OFFSET_NBITS'(1);
          if (&offset) state <= DRAIN;
        end
        DRAIN: if (lastAccept) begin
          rdPtr <= rdPtr + INDEX_NBITS'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/c2f_consumer.md
# c2f_consumer

Drains CPU->FPGA burst-pipe chunks out of the C2F RAM and presents them as a 64-bit valid/ready stream to application logic. Sits directly downstream of `tlp_xcvr`'s CPU->FPGA burst pipe:
- `tlp_xcvr` writes chunks into `ram_sc_be` and publishes the CPU's chunk write pointer.
- This block reads the RAM through its second port.
- It returns the consumer read pointer and a chunk-done acknowledge to `tlp_xcvr` via `c2fRdPtr`/`c2fDTAck`.

## Interface

Parameters:
- `INDEX_NBITS`, default 2: chunk-index width; ring holds 2^INDEX_NBITS chunks.
- `OFFSET_NBITS`, default 4: qword-offset width; each chunk is 2^OFFSET_NBITS qwords.

Ports:
- `clk_in`  in  1  system clock; all logic on rising edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `wrPtr_in`  in  INDEX_NBITS  CPU write pointer (`c2fWrPtr` from `tlp_xcvr`); index of next chunk the CPU will fill.
- `rdPtr_out`  out  INDEX_NBITS  consumer read pointer (to `c2fRdPtr`); index of chunk currently being drained.
- `dtAck_out`  out  1  one-cycle pulse when a chunk has been fully consumed (to `c2fDTAck`).
- `ramAddr_out`  out  INDEX_NBITS+OFFSET_NBITS  RAM read address, `{rdPtr, offset}`.
- `ramData_in`  in  64  RAM read data; registered read, valid exactly 1 cycle after `ramAddr_out`.
- `data_out`  out  64  stream data.
- `valid_out`  out  1  stream valid.
- `ready_in`  in  1  stream ready.
- `last_out`  out  1  qualifies the final qword (offset all-ones) of a chunk.

## Operation

Chunk availability:
- A chunk is available when `rdPtr != wrPtr_in`.
- Empty when they are equal.
- Fullness/overrun is the CPU's responsibility and is not checked.

State machine: IDLE, STREAM, DRAIN.
- IDLE: offset held at 0. If a chunk is available, go to STREAM next cycle; otherwise stay.
- STREAM: issues reads of `{rdPtr, offset}` subject to the issue rule below. On each issue, `offset++`. When the issued offset is all-ones, go to DRAIN.
- DRAIN: issues nothing. Waits for the `last_out` qword to be accepted (`valid_out && ready_in && last_out`). In that cycle:
  - `rdPtr <= rdPtr + 1`, wrapping modulo 2^INDEX_NBITS.
  - `dtAck_out` = 1 for exactly that cycle.
  - Next state is IDLE.
- If the last qword is accepted in the same cycle it would be issued, the transition is still via DRAIN. There is no STREAM->IDLE shortcut.

Read pipeline and skid buffer:
- 2-entry FIFO of {data, last}, plus a 1-bit in-flight flag for the outstanding RAM read.
- Issue rule: issue only when `count + inflight - pop < 2`, where `pop = valid_out && ready_in`. This guarantees no overflow and sustains 1 qword/cycle when `ready_in` is held high.
- RAM data is pushed into the FIFO the cycle after issue. `last` is tagged from the issued offset.
- `valid_out` = FIFO non-empty. `data_out`/`last_out` come from the FIFO head.
- `data_out` and `last_out` are forced to 0 when `valid_out` = 0.

Handshake:
- While `valid_out && !ready_in`, `data_out` and `last_out` stay stable.
- A word is transferred only on `valid_out && ready_in`.
- Order is strictly ascending offset within a chunk, and chunks are strictly in ring order.

Multiple available chunks:
- If `wrPtr_in` jumps by k, k chunks are drained in order.
- Each chunk produces its own `dtAck_out` pulse.
- Exactly one IDLE cycle separates chunks.

## Timing

Reset values:
- `rdPtr_out` = 0, `dtAck_out` = 0, `valid_out` = 0, `data_out` = 0, `last_out` = 0, `ramAddr_out` = 0.
- State IDLE, FIFO empty, in-flight cleared.

Reset mid-operation:
- All of the above take effect on the next edge.
- The in-flight RAM read is discarded.
- No `dtAck_out` is generated for the partial chunk.

Latency with `ready_in` = 1:
- `wrPtr_in` changes before edge E.
- IDLE samples the change at E; STREAM issues the first address in cycle E+1.
- RAM data arrives in E+2 and is pushed at end of E+2.
- `valid_out` rises in cycle E+3.
- A full chunk occupies 2^OFFSET_NBITS consecutive cycles.
- `dtAck_out` coincides with the `last_out` transfer cycle.
- `rdPtr_out` shows the new value in the following cycle.

`wrPtr_in` is only compared in IDLE. Changes during STREAM/DRAIN are seen at the next IDLE.

## Test plan

1. Reset: assert `reset_in` for 2 cycles with garbage inputs -> every output is 0 on the cycle after reset.
2. Single chunk:
   - Stimulus: chunk 0 preloaded with `SEQ64[0..15]`, `ready_in` = 1, `wrPtr_in` 0->1.
   - Required: `valid_out` rises 3 cycles later; 16 back-to-back words `SEQ64[0..15]`; `last_out` only on the 16th word; one `dtAck_out` pulse; `rdPtr_out` = 1; returns to IDLE.
3. Backpressure:
   - Stimulus: same as scenario 2, with `ready_in` toggling 1,0,1,0… and also random.
   - Required: exactly 16 words in order, no duplicates or drops; `data_out` stable while stalled; `dtAck_out` only at the final accept.
4. Multi-chunk:
   - Stimulus: `wrPtr_in` 0->3 in one step.
   - Required: chunks 0, 1, 2 drained in order; 3 `dtAck_out` pulses; one idle cycle between chunks; final `rdPtr_out` = 3.
5. Wrap-around:
   - Stimulus: `rdPtr_out` = 3, then `wrPtr_in` set to 0.
   - Required: chunk 3 (RAM addresses 48..63) is streamed; `rdPtr_out` wraps to 0; the block then idles.
6. Reset mid-chunk:
   - Stimulus: assert reset after 5 of 16 words accepted.
   - Required: `valid_out` = 0 next cycle; `rdPtr_out` = 0; no `dtAck_out`.
   - Follow-up: `wrPtr_in` = 1 after reset -> chunk 0 re-streams from offset 0.
